// File: rtl/fast_pkg.sv
// -----------------------------------------------------------------------------
// fast_pkg
//   Shared types and defaults for the FAST front-end stream sequencer.
//   - fsm_state_t  : frame sequencer states
//   - DEF_*        : default geometry / pixel width
//   - flush_cycles : zero-data enables needed to drain the 7x7 window
//                    (3 patch lines) plus the coordinate delay line
// -----------------------------------------------------------------------------
package fast_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

    localparam int DEF_COL_NUM     = 640;
    localparam int DEF_ROW_NUM     = 480;
    localparam int DEF_PIXEL_WIDTH = 8;

    // Three half-window lines still sit in the line buffers after the last
    // pixel; 12 more enables cover the coordinate/score delay.
    function automatic int flush_cycles(input int col_num);
        return 3 * col_num + 12;
    endfunction

endpackage

// File: rtl/fast_frame_cnt.sv
// -----------------------------------------------------------------------------
// fast_frame_cnt
//   Column/row position counter for one frame.
//   Ports:
//     clk, rst_n  : clock, async active-low reset
//     clr         : synchronous clear (frame start)
//     en          : advance one pixel
//     col_last    : current column is COL_NUM-1
//     frame_last  : current pixel is the last one of the frame
// -----------------------------------------------------------------------------
module fast_frame_cnt #(
    parameter int COL_NUM = 8,
    parameter int ROW_NUM = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic col_last,
    output logic frame_last
);

    localparam int CW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
    localparam int RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign col_last   = (col == CW'(COL_NUM - 1));
    assign frame_last = col_last && (row == RW'(ROW_NUM - 1));

    // row simply increments on each line wrap; it is cleared by the next
    // frame start rather than wrapped here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fast_stream_ctrl.sv
// -----------------------------------------------------------------------------
// fast_stream_ctrl
//   Frame sequencer between the DMA pixel stream and the FAST 7x7 window
//   generator. Forwards accepted pixels as registered data_in/ce pairs,
//   stalls on downstream backpressure, appends FLUSH_CYCLES zero-data enables
//   after the last pixel, then pulses frame_done.
//   Ports:
//     clk, rst_n         : clock, async active-low reset
//     start              : arm one frame (honoured only in IDLE)
//     s_valid/s_ready    : input pixel handshake
//     s_data, s_last     : input pixel, end-of-line marker (checked only)
//     dn_ready           : downstream can accept; low stalls every enable
//     pix_data, pix_ce   : to window generator data_in / ce (registered)
//     busy               : registered "not IDLE"
//     frame_done         : one-cycle pulse, state DONE
//     err_len            : sticky line-length error, cleared by start
// -----------------------------------------------------------------------------
module fast_stream_ctrl
    import fast_pkg::*;
#(
    parameter int COL_NUM      = DEF_COL_NUM,
    parameter int ROW_NUM      = DEF_ROW_NUM,
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int FLUSH_CYCLES = flush_cycles(COL_NUM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    input  logic                   s_last,
    input  logic                   dn_ready,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_ce,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_len
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    fsm_state_t    state, state_nxt;
    logic          beat;
    logic          flush_en;
    logic          clr;
    logic          col_last;
    logic          frame_last;
    logic          flush_last;
    logic [FW-1:0] flush_cnt;

    fast_frame_cnt #(
        .COL_NUM (COL_NUM),
        .ROW_NUM (ROW_NUM)
    ) u_frame_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .en         (beat),
        .col_last   (col_last),
        .frame_last (frame_last)
    );

    assign flush_last = (flush_cnt == FW'(FLUSH_CYCLES - 1));
    assign frame_done = (state == DONE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        beat      = 1'b0;
        flush_en  = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // ready follows downstream combinationally so a stall
                // blocks the beat in the same cycle.
                s_ready = dn_ready;
                beat    = s_valid & dn_ready;
                if (beat && frame_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                flush_en = dn_ready;
                if (flush_en && flush_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------- flush counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        flush_cnt <= '0;
        else if (clr)      flush_cnt <= '0;
        else if (flush_en) flush_cnt <= flush_cnt + 1'b1;
    end

    // --------------------------------------------------- line-length check
    // s_last is only compared against the column position; counting is
    // driven purely by col/row so a bad marker never changes frame length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err_len <= 1'b0;
        else if (clr)                           err_len <= 1'b0;
        else if (beat && (s_last != col_last))  err_len <= 1'b1;
    end

    // ------------------------------------------------- window gen drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_ce   <= 1'b0;
            pix_data <= '0;
            busy     <= 1'b0;
        end else begin
            pix_ce   <= beat | flush_en;
            pix_data <= beat ? s_data : '0;
            busy     <= (state_nxt != IDLE);
        end
    end

endmodule
